multicycle_ctrl: RTL



---
 rtl/legv8_pkg.sv | 50 +++++
 rtl/multicycle_ctrl_opclass_dec.sv | 25 ++
 rtl/multicycle_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 control definitions: opcode constants, ALUOp encodings,
// controller state and opcode-class enums.
package legv8_pkg;

  localparam logic [10:0] OPC_LDUR   = 11'b11111000010;
  localparam logic [10:0] OPC_STUR   = 11'b11111000000;
  localparam logic [7:0]  OPC_CBZ_HI = 8'b10110100;
  localparam logic [10:0] OPC_ADD    = 11'b10001011000;
  localparam logic [10:0] OPC_SUB    = 11'b11001011000;
  localparam logic [10:0] OPC_AND    = 11'b10001010000;
  localparam logic [10:0] OPC_ORR    = 11'b10101010000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXEC_R  = 4'd2,
    MEM_ADR = 4'd3,
    MEM_RD  = 4'd4,
    MEM_WB  = 4'd5,
    MEM_WR  = 4'd6,
    BRANCH  = 4'd7,
    TRAP    = 4'd8
  } state_t;

  typedef enum logic [2:0] {
    R       = 3'd0,
    LDUR    = 3'd1,
    STUR    = 3'd2,
    CBZ     = 3'd3,
    ILLEGAL = 3'd4
  } opclass_t;

  // A store only retires once memory accepts the write.
  function automatic logic retires(input state_t s, input logic mem_ready);
    logic r;
    case (s)
      EXEC_R:  r = 1'b1;
      MEM_WB:  r = 1'b1;
      BRANCH:  r = 1'b1;
      MEM_WR:  r = mem_ready;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_opclass_dec.sv
// Opcode classifier: maps IR[31:21] onto the instruction class used by
// the multicycle controller.
module opclass_dec
  import legv8_pkg::*;
(
  input  logic [10:0] Op,
  output opclass_t    opclass
);

  // Pure decode of the registered opcode field
  always_comb begin
    opclass = ILLEGAL;
    casez (Op)
      OPC_LDUR:              opclass = LDUR;
      OPC_STUR:              opclass = STUR;
      {OPC_CBZ_HI, 3'b???}:  opclass = CBZ;
      OPC_ADD:               opclass = R;
      OPC_SUB:               opclass = R;
      OPC_AND:               opclass = R;
      OPC_ORR:               opclass = R;
      default:               opclass = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// LEGv8 multicycle controller: sequences the datapath over one shared
// variable-latency memory port, counts retired instructions, traps on bad opcodes.
module multicycle_ctrl
  import legv8_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] Op,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        MemReq,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        Reg2Loc,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic [1:0]  ALUOp,
  output logic        illegal,
  output logic [31:0] instret
);

  state_t      state_r;
  state_t      next_s;
  opclass_t    opclass_s;
  logic        retire_s;
  logic        illegal_r;
  logic [31:0] instret_r;

  logic        mem_req_s, mem_write_s, iord_s, ir_write_s, pc_write_s, pc_src_s;
  logic        reg2loc_s, alu_src_s, memto_reg_s, reg_write_s;
  logic [1:0]  alu_op_s;

  opclass_dec u_dec (
    .Op      (Op),
    .opclass (opclass_s)
  );

  assign retire_s = retires(state_r, mem_ready);

  // Next-state selection; memory states hold until mem_ready
  always_comb begin
    next_s = state_r;
    case (state_r)
      FETCH: begin
        if (mem_ready) next_s = DECODE;
        else           next_s = FETCH;
      end
      DECODE: begin
        case (opclass_s)
          R:       next_s = EXEC_R;
          LDUR:    next_s = MEM_ADR;
          STUR:    next_s = MEM_ADR;
          CBZ:     next_s = BRANCH;
          default: next_s = TRAP;
        endcase
      end
      EXEC_R:  next_s = FETCH;
      MEM_ADR: begin
        if (opclass_s == STUR) next_s = MEM_WR;
        else                   next_s = MEM_RD;
      end
      MEM_RD: begin
        if (mem_ready) next_s = MEM_WB;
        else           next_s = MEM_RD;
      end
      MEM_WB:  next_s = FETCH;
      MEM_WR: begin
        if (mem_ready) next_s = FETCH;
        else           next_s = MEM_WR;
      end
      BRANCH:  next_s = FETCH;
      TRAP:    next_s = TRAP;
      default: next_s = FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= FETCH;
    else        state_r <= next_s;
  end

  // Retired-instruction counter, wraps silently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        instret_r <= 32'd0;
    else if (retire_s) instret_r <= instret_r + 32'd1;
    else               instret_r <= instret_r;
  end

  // Sticky illegal flag, raised as DECODE commits to TRAP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                     illegal_r <= 1'b0;
    else if (state_r == DECODE && opclass_s == ILLEGAL) illegal_r <= 1'b1;
    else                                            illegal_r <= illegal_r;
  end

  // Moore output decode; IRWrite/PCWrite also follow mem_ready and Zero
  always_comb begin
    mem_req_s   = 1'b0;
    mem_write_s = 1'b0;
    iord_s      = 1'b0;
    ir_write_s  = 1'b0;
    pc_write_s  = 1'b0;
    pc_src_s    = 1'b0;
    reg2loc_s   = 1'b0;
    alu_src_s   = 1'b0;
    memto_reg_s = 1'b0;
    reg_write_s = 1'b0;
    alu_op_s    = ALUOP_ADD;
    case (state_r)
      FETCH: begin
        mem_req_s  = 1'b1;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
      end
      EXEC_R: begin
        alu_op_s    = ALUOP_RTYPE;
        reg_write_s = 1'b1;
      end
      MEM_ADR: begin
        alu_src_s = 1'b1;
        if (opclass_s == STUR) reg2loc_s = 1'b1;
        else                   reg2loc_s = 1'b0;
      end
      MEM_RD: begin
        mem_req_s = 1'b1;
        iord_s    = 1'b1;
      end
      MEM_WB: begin
        memto_reg_s = 1'b1;
        reg_write_s = 1'b1;
      end
      MEM_WR: begin
        mem_req_s   = 1'b1;
        mem_write_s = 1'b1;
        iord_s      = 1'b1;
        reg2loc_s   = 1'b1;
      end
      BRANCH: begin
        reg2loc_s  = 1'b1;
        alu_op_s   = ALUOP_PASSB;
        pc_write_s = Zero;
        pc_src_s   = 1'b1;
      end
      default: begin
        mem_req_s = 1'b0;
      end
    endcase
  end

  // Reset low forces every control inactive even though the state sits in FETCH
  assign MemReq   = mem_req_s   & reset;
  assign MemWrite = mem_write_s & reset;
  assign IorD     = iord_s      & reset;
  assign IRWrite  = ir_write_s  & reset;
  assign PCWrite  = pc_write_s  & reset;
  assign PCSrc    = pc_src_s    & reset;
  assign Reg2Loc  = reg2loc_s   & reset;
  assign ALUSrc   = alu_src_s   & reset;
  assign MemtoReg = memto_reg_s & reset;
  assign RegWrite = reg_write_s & reset;
  assign ALUOp    = alu_op_s    & {2{reset}};
  assign illegal  = illegal_r;
  assign instret  = instret_r;

endmodule
